// File: rtl/floo_pkg.sv
// Shared FlooNoC router types: route directions, XY coordinates and the XY
// dimension-ordered routing function used by every mesh router port.
package floo_pkg;

  localparam int unsigned XYWidth       = 3;
  localparam int unsigned NumDirections = 5;

  typedef enum logic [2:0] {
    Eject = 3'd0,
    North = 3'd1,
    East  = 3'd2,
    South = 3'd3,
    West  = 3'd4
  } route_direction_e;

  // Packed so that {y, x} bit concatenations map directly onto the struct.
  typedef struct packed {
    logic [XYWidth-1:0] y;
    logic [XYWidth-1:0] x;
  } xy_id_t;

  // X is resolved before Y; all compares are unsigned.
  function automatic route_direction_e xy_route(xy_id_t dst, xy_id_t own);
    route_direction_e dir;
    if (dst.x > own.x)      dir = East;
    else if (dst.x < own.x) dir = West;
    else if (dst.y > own.y) dir = North;
    else if (dst.y < own.y) dir = South;
    else                    dir = Eject;
    return dir;
  endfunction

endpackage

// File: rtl/floo_route_fifo.sv
// Generic 2-entry in-order FIFO with full throughput; ready_o is derived
// from registered occupancy only.
module floo_route_fifo #(
  parameter type entry_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   valid_i,
  output logic   ready_o,
  input  entry_t data_i,
  output logic   valid_o,
  input  logic   ready_i,
  output entry_t data_o
);

  entry_t     r_mem [2];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign ready_o = (r_count != 2'd2);
  assign valid_o = (r_count != 2'd0);
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = valid_i && ready_o;
  assign w_pop   = valid_o && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/floo_xy_route_stage.sv
// Mesh router input stage: XY route on header flits, wormhole lock of the
// route for body flits, and a 2-entry buffer of {data, last, route}.
module floo_xy_route_stage
  import floo_pkg::*;
#(
  parameter int unsigned XYWidth      = 3,
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned NumRoutes    = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [2*XYWidth-1:0]    xy_id_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [XYWidth-1:0]      dst_x_i,
  input  logic [XYWidth-1:0]      dst_y_i,
  input  logic                    last_i,
  input  logic [PayloadWidth-1:0] data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [PayloadWidth-1:0] data_o,
  output logic                    last_o,
  output logic [2:0]              route_dir_o,
  output logic [NumRoutes-1:0]    route_sel_o
);

  typedef struct packed {
    logic [PayloadWidth-1:0] data;
    logic                    last;
    route_direction_e        route;
  } flit_t;

  typedef enum logic {
    Idle   = 1'b0,
    Locked = 1'b1
  } lock_state_e;

  lock_state_e      r_state;
  lock_state_e      w_state_next;
  route_direction_e r_route_q;
  route_direction_e w_route;
  xy_id_t           w_own;
  xy_id_t           w_dst;
  logic             w_in_hs;
  flit_t            w_flit_in;
  flit_t            w_head;

  assign w_own   = xy_id_i;
  assign w_dst   = {dst_y_i, dst_x_i};
  assign w_in_hs = valid_i && ready_o;

  always_comb begin
    w_state_next = r_state;
    w_route      = r_route_q;
    case (r_state)
      Idle: begin
        w_route = xy_route(w_dst, w_own);
        if (w_in_hs && !last_i) w_state_next = Locked;
      end
      Locked: begin
        if (w_in_hs && last_i) w_state_next = Idle;
      end
      default: w_state_next = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= Idle;
      r_route_q <= Eject;
    end else begin
      r_state <= w_state_next;
      if (w_in_hs && (r_state == Idle) && !last_i) r_route_q <= w_route;
    end
  end

  assign w_flit_in = '{data: data_i, last: last_i, route: w_route};

  floo_route_fifo #(
    .entry_t (flit_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (w_flit_in),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (w_head)
  );

  assign data_o      = w_head.data;
  assign last_o      = w_head.last;
  assign route_dir_o = w_head.route;
  assign route_sel_o = NumRoutes'(1) << route_dir_o;

endmodule

// File: tb/tb_floo_xy_route_stage.sv
// Bench for floo_xy_route_stage: directed routing/lock/stall/reset cases
// followed by random valid/ready traffic against a scoreboard.
module tb_floo_xy_route_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [5:0]  xy_id_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  dst_x_i;
  logic [2:0]  dst_y_i;
  logic        last_i;
  logic [63:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] data_o;
  logic        last_o;
  logic [2:0]  route_dir_o;
  logic [4:0]  route_sel_o;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [2:0]  dir;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        m_locked = 1'b0;
  logic [2:0]  m_lock_dir = 3'd0;

  always #5 clk = ~clk;

  floo_xy_route_stage #(
    .XYWidth      (3),
    .PayloadWidth (64),
    .NumRoutes    (5)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .xy_id_i     (xy_id_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .dst_x_i     (dst_x_i),
    .dst_y_i     (dst_y_i),
    .last_i      (last_i),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .last_o      (last_o),
    .route_dir_o (route_dir_o),
    .route_sel_o (route_sel_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Codes: Eject 0, North 1, East 2, South 3, West 4
  function automatic logic [2:0] ref_route(logic [2:0] dx, logic [2:0] dy,
                                           logic [2:0] ox, logic [2:0] oy);
    if (dx > ox) return 3'd2;
    if (dx < ox) return 3'd4;
    if (dy > oy) return 3'd1;
    if (dy < oy) return 3'd3;
    return 3'd0;
  endfunction

  // Scoreboard: handshakes are sampled on the falling edge, where inputs
  // and registered outputs hold the values the next rising edge will see.
  always @(negedge clk) begin
    if (rst_i) begin
      sb.delete();
      m_locked = 1'b0;
    end else begin
      check("sel_onehot", 64'($countones(route_sel_o)), 64'd1);
      check("sel_decode", 64'(route_sel_o), 64'(5'd1 << route_dir_o));
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_flit", 64'(valid_o), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_data", data_o, e.data);
          check("sb_last", 64'(last_o), 64'(e.last));
          check("sb_route", 64'(route_dir_o), 64'(e.dir));
        end
      end
      if (valid_i && ready_o) begin
        exp_t e;
        if (!m_locked) e.dir = ref_route(dst_x_i, dst_y_i, xy_id_i[2:0], xy_id_i[5:3]);
        else           e.dir = m_lock_dir;
        if (!m_locked && !last_i) begin
          m_locked   = 1'b1;
          m_lock_dir = e.dir;
        end else if (last_i) begin
          m_locked = 1'b0;
        end
        e.data = data_i;
        e.last = last_i;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [2:0] dx, input logic [2:0] dy,
                      input logic lst, input logic [63:0] d);
    logic acc;
    valid_i = 1'b1;
    dst_x_i = dx;
    dst_y_i = dy;
    last_i  = lst;
    data_i  = d;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_o"}, 64'(valid_o), 64'd0);
    check({tag, "_ready_o"}, 64'(ready_o), 64'd1);
    check({tag, "_dir"},     64'(route_dir_o), 64'd0);
    check({tag, "_sel"},     64'(route_sel_o), 64'b00001);
    check({tag, "_last"},    64'(last_o), 64'd0);
    check({tag, "_data"},    data_o, 64'd0);
  endtask

  initial begin
    logic [2:0]  dx[5];
    logic [2:0]  dy[5];
    logic [2:0]  edir[5];
    logic [4:0]  esel[5];
    time         t0;
    int          acc_n;
    logic        acc;

    rst_i   = 1'b1;
    xy_id_i = {3'd2, 3'd2};
    valid_i = 1'b0;
    dst_x_i = '0;
    dst_y_i = '0;
    last_i  = 1'b0;
    data_i  = '0;
    ready_i = 1'b1;
    tick(3);
    rst_i = 1'b0;
    check_reset_outputs("reset");

    // Single-flit packets from own (2,2), one per direction.
    dx   = '{3'd3, 3'd1, 3'd2, 3'd2, 3'd2};
    dy   = '{3'd2, 3'd2, 3'd3, 3'd1, 3'd2};
    edir = '{3'd2, 3'd4, 3'd1, 3'd3, 3'd0};
    esel = '{5'b00100, 5'b10000, 5'b00010, 5'b01000, 5'b00001};
    for (int i = 0; i < 5; i++) begin
      send(dx[i], dy[i], 1'b1, 64'h100 + 64'(i));
      valid_i = 1'b0;
      check("single_valid", 64'(valid_o), 64'd1);
      check("single_dir", 64'(route_dir_o), 64'(edir[i]));
      check("single_sel", 64'(route_sel_o), 64'(esel[i]));
      tick(1);
    end

    // 4-flit packet: header to (0,5); body dst fields must be ignored.
    for (int i = 0; i < 4; i++) begin
      if (i == 0) send(3'd0, 3'd5, 1'b0, 64'h200);
      else        send(3'd3, 3'd3, (i == 3), 64'h200 + 64'(i));
      check("lock_dir", 64'(route_dir_o), 64'd4);
      check("lock_last", 64'(last_o), 64'(i == 3));
    end
    valid_i = 1'b0;
    tick(2);

    // Back-to-back packets: A (2 flits East) then B header North.
    t0 = $time;
    send(3'd3, 3'd2, 1'b0, 64'h300);
    send(3'd0, 3'd0, 1'b1, 64'h301);
    check("b2b_a_dir", 64'(route_dir_o), 64'd2);
    send(3'd2, 3'd3, 1'b1, 64'h302);
    valid_i = 1'b0;
    check("b2b_b_dir", 64'(route_dir_o), 64'd1);
    check("b2b_cycles", 64'(($time - t0) / 10), 64'd3);
    tick(2);

    // Downstream stall with continuous valid_i.
    ready_i = 1'b0;
    acc_n   = 0;
    dst_x_i = 3'd3;
    dst_y_i = 3'd2;
    for (int k = 0; k < 5; k++) begin
      valid_i = 1'b1;
      data_i  = 64'h400 + 64'(acc_n);
      last_i  = (acc_n != 0);
      @(negedge clk);
      if (acc_n > 0) begin
        check("stall_data", data_o, 64'h400);
        check("stall_dir", 64'(route_dir_o), 64'd2);
        check("stall_last", 64'(last_o), 64'd0);
      end
      if (ready_o) acc_n++;
      @(posedge clk);
      #1;
    end
    check("stall_accepts", 64'(acc_n), 64'd2);
    check("stall_ready_low", 64'(ready_o), 64'd0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick(4);
    check("stall_drained", 64'(sb.size()), 64'd0);
    check("stall_valid_low", 64'(valid_o), 64'd0);

    // Reset mid-packet after two body flits.
    send(3'd0, 3'd0, 1'b0, 64'h500);
    send(3'd1, 3'd1, 1'b0, 64'h501);
    send(3'd1, 3'd1, 1'b0, 64'h502);
    valid_i = 1'b0;
    rst_i   = 1'b1;
    tick(1);
    rst_i = 1'b0;
    check_reset_outputs("midrst");
    send(3'd2, 3'd4, 1'b1, 64'h600);
    valid_i = 1'b0;
    check("midrst_new_dir", 64'(route_dir_o), 64'd1);
    tick(2);

    // Random traffic, occasionally moving own coordinates.
    acc = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!valid_i || acc) begin
        valid_i = ($urandom_range(0, 3) != 0);
        dst_x_i = 3'($urandom_range(0, 7));
        dst_y_i = 3'($urandom_range(0, 7));
        last_i  = ($urandom_range(0, 3) == 0);
        data_i  = {$urandom, $urandom};
      end
      ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) xy_id_i = 6'($urandom_range(0, 63));
      @(negedge clk);
      acc = valid_i && ready_o;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) tick(1);
    check("final_drained", 64'(sb.size()), 64'd0);
    check("final_valid_low", 64'(valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
